// File: rtl/otn_rx_deframer.sv
// otn_rx_deframer: OTN receive FAS hunt, byte deserializer, checksum and serial ARQ ACK.
// Define OTN_RX_STATS_EN to add saturating good/bad frame counters.
module otn_rx_deframer #(
  parameter int FRAME_BYTES = 4164,
  parameter int SYNC_STAGES = 2,
  parameter logic [47:0] FAS_PATTERN = 48'h28_28_28_F6_F6_F6
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_otn_rx_data,
  input  logic        i_arq_en,
  output logic        o_otn_tx_ack,
  output logic [7:0]  o_frame_data,
  output logic        o_frame_data_valid,
  output logic        o_frame_sof,
  output logic        o_frame_eof,
  output logic        o_frame_ok,
`ifdef OTN_RX_STATS_EN
  output logic [15:0] o_good_cnt,
  output logic [15:0] o_bad_cnt,
`endif
  output logic        o_locked
);
  localparam logic [7:0] FAS_XOR = FAS_PATTERN[7:0] ^ FAS_PATTERN[15:8] ^ FAS_PATTERN[23:16] ^
                                   FAS_PATTERN[31:24] ^ FAS_PATTERN[39:32] ^ FAS_PATTERN[47:40];
  typedef enum logic [2:0] {HUNT, RECV, ACK_START, ACK_BIT, ACK_STOP} state_t;
  state_t state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic [47:0] win_nxt, win;
  logic [6:0] shift;
  logic [7:0] byte_nxt, chk;
  logic [2:0] bit_cnt;
  logic [12:0] byte_cnt;
  logic rx_bit, fas_hit, byte_done, last_byte, frame_end, ok_nxt, ok_lat, sof_pending, ack_nxt;
  assign rx_bit    = sync[SYNC_STAGES-1];
  assign win_nxt   = {rx_bit, win[47:1]};
  assign fas_hit   = state == HUNT && win_nxt == FAS_PATTERN;
  assign byte_done = state == RECV && bit_cnt == 3'd7;
  assign last_byte = byte_cnt == 13'(FRAME_BYTES - 1);
  assign frame_end = byte_done && last_byte;
  assign byte_nxt  = {rx_bit, shift};
  assign ok_nxt    = (chk ^ byte_nxt) == 8'h00;
  assign o_locked  = state == RECV;
  always_ff @(posedge i_clk) state <= i_rst ? HUNT : state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      HUNT:      state_nxt = fas_hit ? RECV : HUNT;
      RECV:      state_nxt = frame_end ? (i_arq_en ? ACK_START : HUNT) : RECV;
      ACK_START: state_nxt = ACK_BIT;
      ACK_BIT:   state_nxt = ACK_STOP;
      default:   state_nxt = HUNT;
    endcase
  end
  // ACK is registered, so it is derived from the state being entered.
  always_comb ack_nxt = !(state_nxt == ACK_START || state_nxt == ACK_STOP || (state_nxt == ACK_BIT && !ok_lat));
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync               <= '1;
      win                <= '0;
      shift              <= '0;
      bit_cnt            <= '0;
      byte_cnt           <= '0;
      chk                <= '0;
      sof_pending        <= 1'b0;
      ok_lat             <= 1'b0;
      o_frame_data       <= '0;
      o_frame_data_valid <= 1'b0;
      o_frame_sof        <= 1'b0;
      o_frame_eof        <= 1'b0;
      o_frame_ok         <= 1'b0;
      o_otn_tx_ack       <= 1'b1;
    end else begin
      sync               <= {sync[SYNC_STAGES-2:0], i_otn_rx_data};
      win                <= (state == HUNT && !fas_hit) ? win_nxt : '0;
      shift              <= state == RECV ? {rx_bit, shift[6:1]} : shift;
      bit_cnt            <= state == RECV ? bit_cnt + 3'd1 : 3'd0;
      o_frame_data_valid <= byte_done;
      o_frame_sof        <= byte_done && sof_pending;
      o_frame_eof        <= frame_end;
      o_frame_ok         <= frame_end && ok_nxt;
      o_otn_tx_ack       <= ack_nxt;
      if (fas_hit) begin
        byte_cnt    <= 13'd6;
        chk         <= FAS_XOR;
        sof_pending <= 1'b1;
      end
      if (byte_done) begin
        o_frame_data <= byte_nxt;
        chk          <= chk ^ byte_nxt;
        byte_cnt     <= byte_cnt + 13'd1;
        sof_pending  <= 1'b0;
      end
      if (frame_end) ok_lat <= ok_nxt;
    end
  end
`ifdef OTN_RX_STATS_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_good_cnt <= '0;
      o_bad_cnt  <= '0;
    end else if (frame_end) begin
      o_good_cnt <= (ok_nxt && o_good_cnt != 16'hFFFF) ? o_good_cnt + 16'd1 : o_good_cnt;
      o_bad_cnt  <= (!ok_nxt && o_bad_cnt != 16'hFFFF) ? o_bad_cnt + 16'd1 : o_bad_cnt;
    end
  end
`endif
endmodule

// File: tb/tb_otn_rx_deframer.sv
// tb_otn_rx_deframer: frame-level expectations scheduled per cycle from frame geometry.
`timescale 1ns/1ps
module tb_otn_rx_deframer;
  localparam int N  = 32;
  localparam int NC = 1600;
  logic clk = 1'b0;
  logic rst = 1'b1, rxd = 1'b1, arq = 1'b0;
  logic ack, valid, sof, eof, ok, locked;
  logic [7:0] data;
`ifdef OTN_RX_STATS_EN
  logic [15:0] good_cnt, bad_cnt;
`endif
  int tests = 0, fails = 0;
  int pos, g, b;
  logic dbit [NC];
  logic drst [NC];
  logic darq [NC];
  logic ev [NC];
  logic es [NC];
  logic ee [NC];
  logic eo [NC];
  logic ea [NC];
  logic el [NC];
  logic ig [NC];
  logic ib [NC];
  logic rv [NC];
  logic [7:0] ed [NC];
  logic [7:0] fb [N];

  always #5 clk = ~clk;

  otn_rx_deframer #(.FRAME_BYTES(N)) dut (
    .i_clk(clk), .i_rst(rst), .i_otn_rx_data(rxd), .i_arq_en(arq),
    .o_otn_tx_ack(ack), .o_frame_data(data), .o_frame_data_valid(valid),
    .o_frame_sof(sof), .o_frame_eof(eof), .o_frame_ok(ok),
`ifdef OTN_RX_STATS_EN
    .o_good_cnt(good_cnt), .o_bad_cnt(bad_cnt),
`endif
    .o_locked(locked));

  task automatic chk(input string tag, input int c, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s cycle %0d: got %0h expected %0h", tag, c, got, exp);
    end
  endtask

  // Frame with FAS, random payload and a last byte that makes the XOR of all bytes zero.
  task automatic mk(input logic fas_inside);
    logic [7:0] x;
    for (int j = 0; j < 3; j++) fb[j] = 8'hF6;
    for (int j = 3; j < 6; j++) fb[j] = 8'h28;
    for (int j = 6; j < N - 1; j++) fb[j] = 8'($urandom);
    if (fas_inside) for (int j = 0; j < 6; j++) fb[8 + j] = fb[j];
    x = 8'h00;
    for (int j = 0; j < N - 1; j++) x ^= fb[j];
    fb[N - 1] = x;
  endtask

  // Bit driven in cycle d is consumed by the deframer at edge d+3 (two sync flops).
  task automatic send(input int junk, input logic a, input int abort_at);
    int s, r, vl, v;
    logic fok;
    logic [7:0] x;
    for (int i = 0; i < junk; i++) begin
      dbit[pos] = (i != 1);
      pos++;
    end
    s = pos;
    x = 8'h00;
    for (int j = 0; j < N; j++) x ^= fb[j];
    fok = (x == 8'h00);
    r  = abort_at > 0 ? s + 8 * abort_at + 3 : NC;
    vl = s + 8 * N + 2;
    for (int j = 0; j < N; j++)
      for (int k = 0; k < 8; k++)
        if (s + 8 * j + k < r) dbit[s + 8 * j + k] = fb[j][k];
    for (int c = s + 50; c < vl && c <= r; c++) el[c] = 1'b1;
    for (int j = 6; j < N; j++) begin
      v = s + 8 * j + 10;
      if (v <= r) begin
        ev[v] = 1'b1;
        ed[v] = fb[j];
        es[v] = (j == 6);
        ee[v] = (j == N - 1);
        eo[v] = fok;
      end
    end
    if (abort_at > 0) begin
      drst[r]   = 1'b1;
      rv[r + 1] = 1'b1;
      pos = r + 17;
    end else begin
      darq[vl - 1] = a;
      if (a) begin
        ea[vl]     = 1'b0;
        ea[vl + 1] = fok;
        ea[vl + 2] = 1'b0;
      end
      if (fok) ig[vl] = 1'b1;
      else ib[vl] = 1'b1;
      pos = vl + 16;
    end
  endtask

  initial begin
    for (int c = 0; c < NC; c++) begin
      dbit[c] = 1'b1; drst[c] = 1'b0; darq[c] = 1'($urandom);
      ev[c] = 1'b0; es[c] = 1'b0; ee[c] = 1'b0; eo[c] = 1'b0;
      ea[c] = 1'b1; el[c] = 1'b0; ig[c] = 1'b0; ib[c] = 1'b0; rv[c] = 1'b0; ed[c] = 8'h00;
    end
    for (int c = 0; c < 3; c++) begin
      drst[c] = 1'b1;
      rv[c + 1] = 1'b1;
    end
    pos = 14;
    mk(1'b1);
    send(0, 1'b1, 0);
    send(0, 1'b1, 20);
    fb[20] = fb[20] == 8'h55 ? 8'hAA : 8'h55;
    send(0, 1'b1, 0);
    mk(1'b0);
    send(0, 1'b0, 0);
    mk(1'b0);
    send(3, 1'b1, 0);
    g = 0;
    b = 0;
    for (int c = 0; c < NC; c++) begin
      @(negedge clk);
      if (rv[c]) begin
        g = 0;
        b = 0;
      end
      g += int'(ig[c]);
      b += int'(ib[c]);
      if (c > 0) begin
        chk("valid", c, 16'(valid), 16'(ev[c]));
        chk("ack", c, 16'(ack), 16'(ea[c]));
        chk("locked", c, 16'(locked), 16'(el[c]));
        if (ev[c]) begin
          chk("data", c, 16'(data), 16'(ed[c]));
          chk("sof", c, 16'(sof), 16'(es[c]));
          chk("eof", c, 16'(eof), 16'(ee[c]));
        end
        if (ee[c]) chk("ok", c, 16'(ok), 16'(eo[c]));
`ifdef OTN_RX_STATS_EN
        chk("good_cnt", c, good_cnt, 16'(g));
        chk("bad_cnt", c, bad_cnt, 16'(b));
`endif
      end
      rst = drst[c];
      rxd = dbit[c];
      arq = darq[c];
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
